cpu_test_monitor: RTL and testbench

//  Synthesisable self-check monitor paired with the cpu core for on-board and simulated program tests.

---
 rtl/cpu_test_pkg.sv | 13 +
 rtl/cpu_test_monitor_sat_counter.sv | 19 +
 rtl/cpu_test_monitor.sv | 116 +++++++++++
 tb/tb_cpu_test_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_test_pkg.sv
// Shared encodings and default mailbox addresses for the cpu test monitor.
package cpu_test_pkg;
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
  localparam logic [31:0] SIG_BASE_DEF    = 32'h0000_1100;
endpackage

// File: rtl/cpu_test_monitor_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);
  assign sat = &count;

  always_ff @(posedge clk) begin
    if (!rst)             count <= '0;
    else if (clr)         count <= '0;
    else if (en && !sat)  count <= count + W'(1);
  end
endmodule

// File: rtl/cpu_test_monitor.sv
// Snoops stores and fetch PC, decides PASS/FAIL/TIMEOUT/HANG, captures signatures.
module cpu_test_monitor
  import cpu_test_pkg::*;
#(
  parameter int               ADDR_W         = 32,
  parameter int               DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR   = ADDR_W'(TOHOST_ADDR_DEF),
  parameter logic [ADDR_W-1:0] SIG_BASE      = ADDR_W'(SIG_BASE_DEF),
  parameter int               NUM_SIG        = 8,
  parameter int               TIMEOUT_CYCLES = 1_000_000,
  parameter int               HANG_CYCLES    = 1024,
  parameter int               CNT_W          = 32,
  localparam int              IDX_W          = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1,
  localparam int              SC_W           = $clog2(NUM_SIG) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_we,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  input  logic [IDX_W-1:0]  sig_idx,
  output logic [DATA_W-1:0] sig_data,
  output logic [SC_W-1:0]   sig_count,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-2:0] fail_code,
  output logic [CNT_W-1:0]  cycles,
  output logic [15:0]       led
);
  state_e              state, state_nxt;
  logic [DATA_W-1:0]   sig_q [NUM_SIG];
  logic [NUM_SIG-1:0]  sig_wr;
  logic [ADDR_W-1:0]   last_pc;
  logic                last_pc_vld;
  logic [CNT_W-1:0]    hang_cnt;
  logic                cyc_sat, hang_sat;

  wire run    = (state == ST_RUN);
  wire tohost = st_we && (st_addr == TOHOST_ADDR);
  wire rep    = pc_valid && last_pc_vld && (pc == last_pc);

  // Word offset from the signature base; addresses below the base wrap high and miss.
  wire [ADDR_W-3:0] sig_off = st_addr[ADDR_W-1:2] - SIG_BASE[ADDR_W-1:2];
  wire              sig_hit = st_we && (sig_off < (ADDR_W-2)'(NUM_SIG));
  wire [IDX_W-1:0]  slot    = sig_off[IDX_W-1:0];

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .rst(rst), .en(run && !cyc_sat), .clr(1'b0),
    .count(cycles), .sat(cyc_sat)
  );

  sat_counter #(.W(CNT_W)) u_hang (
    .clk(clk), .rst(rst), .en(run && rep && !hang_sat), .clr(run && pc_valid && !rep),
    .count(hang_cnt), .sat(hang_sat)
  );

  always_comb begin
    state_nxt = state;
    if (run) begin
      if (tohost && st_wdata == DATA_W'(1))
        state_nxt = ST_PASS;
      else if (tohost && st_wdata[0])
        state_nxt = ST_FAIL;
      else if (TIMEOUT_CYCLES != 0 && cycles == CNT_W'(TIMEOUT_CYCLES - 1))
        state_nxt = ST_TIMEOUT;
      else if (HANG_CYCLES != 0 && hang_cnt == CNT_W'(HANG_CYCLES - 1))
        state_nxt = ST_HANG;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= '0;
      sig_count   <= '0;
      sig_wr      <= '0;
      last_pc     <= '0;
      last_pc_vld <= 1'b0;
      for (int i = 0; i < NUM_SIG; i++) sig_q[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt != ST_RUN);
      pass  <= (state_nxt == ST_PASS);
      if (run && state_nxt == ST_FAIL) fail_code <= st_wdata[DATA_W-1:1];
      if (run && sig_hit) begin
        sig_q[slot] <= st_wdata;
        sig_wr[slot] <= 1'b1;
        if (!sig_wr[slot]) sig_count <= sig_count + SC_W'(1);
      end
      if (run && pc_valid) begin
        last_pc     <= pc;
        last_pc_vld <= 1'b1;
      end
    end
  end

  assign sig_data = (int'(sig_idx) < NUM_SIG) ? sig_q[sig_idx] : '0;

  always_comb begin
    led     = '0;
    led[15] = done;
    led[14] = pass;
    led[13] = (state == ST_TIMEOUT);
    led[12] = (state == ST_HANG);
    case (state)
      ST_RUN:  led[11:0] = cycles[CNT_W-1 -: 12];
      ST_FAIL: led[11:0] = fail_code[11:0];
      ST_PASS: led[11:0] = 12'(sig_count);
      default: led[11:0] = last_pc[13:2];
    endcase
  end
endmodule

// File: tb/tb_cpu_test_monitor.sv
// Scoreboard bench for cpu_test_monitor: verdicts, signatures, watchdogs, reset.
module tb_cpu_test_monitor;
  logic        clk = 1'b0, rst = 1'b0;
  logic        st_we = 1'b0, pc_valid = 1'b0;
  logic [31:0] st_addr = '0, st_wdata = '0, pc = '0;
  logic [2:0]  sig_idx = '0;
  logic [31:0] sig_data, cycles;
  logic [3:0]  sig_count;
  logic        done, pass;
  logic [30:0] fail_code;
  logic [15:0] led;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic [30:0] fail_code;
    logic [15:0] led;
    logic [31:0] cycles;
  } obs_t;

  obs_t exp_q[$];
  obs_t e, o;
  int   checks = 0, errors = 0;

  cpu_test_monitor #(.TIMEOUT_CYCLES(100), .HANG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .st_we(st_we), .st_addr(st_addr), .st_wdata(st_wdata),
    .pc_valid(pc_valid), .pc(pc), .sig_idx(sig_idx), .sig_data(sig_data),
    .sig_count(sig_count), .done(done), .pass(pass), .fail_code(fail_code),
    .cycles(cycles), .led(led)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic d, logic p, logic [30:0] fc, logic [15:0] l, logic [31:0] c);
    return '{done: d, pass: p, fail_code: fc, led: l, cycles: c};
  endfunction

  function automatic obs_t sample();
    return '{done: done, pass: pass, fail_code: fail_code, led: led, cycles: cycles};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    st_we = 1'b1; st_addr = a; st_wdata = d;
    step();
    st_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; st_we = 1'b0; pc_valid = 1'b0; pc = '0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(mk(0, 0, 0, 16'h0000, 0));
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_outputs got %h exp %h", o, e); end
    sig_idx = 3'd0; #1; checks++;
    if ({sig_count, sig_data} !== 36'h0) begin
      errors++; $display("FAIL reset_sig got cnt %0d data %h exp 0", sig_count, sig_data);
    end
  endtask

  task automatic test_pass();
    do_reset();
    store(32'h1100, 32'h1234);
    idle(48);
    exp_q.push_back(mk(1, 1, 0, 16'hC001, 50));
    store(32'h1000, 32'h1);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL pass_verdict got %h exp %h", o, e); end
    exp_q.push_back(mk(1, 1, 0, 16'hC001, 50));
    idle(5);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL pass_frozen got %h exp %h", o, e); end
  endtask

  task automatic test_fail();
    do_reset();
    store(32'h1000, 32'h0);
    exp_q.push_back(mk(0, 0, 0, 16'h0000, 2));
    store(32'h1000, 32'h2);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL fail_even_ignored got %h exp %h", o, e); end
    exp_q.push_back(mk(1, 0, 31'd3, 16'h8003, 3));
    store(32'h1000, 32'h7);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL fail_verdict got %h exp %h", o, e); end
    exp_q.push_back(mk(1, 0, 31'd3, 16'h8003, 3));
    store(32'h1000, 32'h1);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL fail_sticky got %h exp %h", o, e); end
  endtask

  task automatic test_signature();
    logic [31:0] m [8];
    logic [31:0] addrs [6] = '{32'h1100, 32'h111C, 32'h1100, 32'h1120, 32'h10FC, 32'h1107};
    logic [31:0] vals  [6] = '{32'hA5, 32'h5A, 32'hFF, 32'h77, 32'h33, 32'h11};
    logic [7:0]  wr = '0;
    int          cnt = 0;
    logic [31:0] sd_q[$];
    for (int i = 0; i < 8; i++) m[i] = '0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (addrs[k] >= 32'h1100 && addrs[k] < 32'h1120) begin
        m[(addrs[k] - 32'h1100) >> 2] = vals[k];
        if (!wr[(addrs[k] - 32'h1100) >> 2]) cnt++;
        wr[(addrs[k] - 32'h1100) >> 2] = 1'b1;
      end
      store(addrs[k], vals[k]);
    end
    for (int i = 0; i < 8; i++) sd_q.push_back(m[i]);
    for (int i = 0; i < 8; i++) begin
      sig_idx = 3'(i); #1;
      checks++;
      if (sig_data !== sd_q[0]) begin
        errors++; $display("FAIL sig_slot%0d got %h exp %h", i, sig_data, sd_q[0]);
      end
      void'(sd_q.pop_front());
    end
    checks++;
    if (sig_count !== 4'(cnt)) begin
      errors++; $display("FAIL sig_count got %0d exp %0d", sig_count, cnt);
    end
    store(32'h1000, 32'h1);
    store(32'h1104, 32'h99);
    sig_idx = 3'd1; #1; checks++;
    if ({sig_data, led} !== {32'h11, 16'hC003}) begin
      errors++; $display("FAIL sig_terminal got %h/%h exp 11/c003", sig_data, led);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    exp_q.push_back(mk(0, 0, 0, 16'h0000, 99));
    idle(99);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL timeout_before got %h exp %h", o, e); end
    exp_q.push_back(mk(1, 0, 0, 16'hA000, 100));
    step();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL timeout_verdict got %h exp %h", o, e); end
    do_reset();
    idle(99);
    exp_q.push_back(mk(1, 1, 0, 16'hC000, 100));
    store(32'h1000, 32'h1);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL timeout_race_pass got %h exp %h", o, e); end
  endtask

  task automatic test_hang();
    do_reset();
    pc = 32'h40; pc_valid = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 16'h0000, 16));
    idle(16);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL hang_before got %h exp %h", o, e); end
    exp_q.push_back(mk(1, 0, 0, 16'h9010, 17));
    step();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL hang_verdict got %h exp %h", o, e); end
    // gap in pc_valid holds the count
    do_reset();
    pc = 32'h40; pc_valid = 1'b1; idle(8);
    pc_valid = 1'b0; idle(5);
    pc_valid = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 16'h0000, 21));
    idle(8);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL hang_gap_before got %h exp %h", o, e); end
    exp_q.push_back(mk(1, 0, 0, 16'h9010, 22));
    step();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL hang_gap_verdict got %h exp %h", o, e); end
    // pc change restarts the count
    do_reset();
    pc = 32'h40; pc_valid = 1'b1; idle(10);
    pc = 32'h44; step();
    exp_q.push_back(mk(0, 0, 0, 16'h0000, 26));
    idle(15);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL hang_change_before got %h exp %h", o, e); end
    exp_q.push_back(mk(1, 0, 0, 16'h9011, 27));
    step();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL hang_change_verdict got %h exp %h", o, e); end
    pc_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    store(32'h1100, 32'hAB);
    store(32'h1000, 32'h1);
    exp_q.push_back(mk(0, 0, 0, 16'h0000, 0));
    rst = 1'b0; step(); rst = 1'b1;
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL midreset_outputs got %h exp %h", o, e); end
    sig_idx = 3'd0; #1; checks++;
    if ({sig_count, sig_data} !== 36'h0) begin
      errors++; $display("FAIL midreset_sig got cnt %0d data %h exp 0", sig_count, sig_data);
    end
    store(32'h1100, 32'h42);
    exp_q.push_back(mk(1, 0, 31'd2, 16'h8002, 2));
    store(32'h1000, 32'h5);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL midreset_rerun got %h exp %h", o, e); end
    checks++;
    if ({sig_count, sig_data} !== {4'd1, 32'h42}) begin
      errors++; $display("FAIL midreset_rerun_sig got cnt %0d data %h exp 1/42", sig_count, sig_data);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_signature();
    test_timeout();
    test_hang();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
